// File: rtl/count_direction_decoder.sv
// Decodes direction, steps, jumps and stalls from a sampled 3-bit up/down counter,
// accumulating a wrapping signed position and a saturating jump-error count.
module count_direction_decoder #(
   parameter int POS_W     = 8,
   parameter int STALL_LIM = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       cnt_in,
   output logic             dir,
   output logic             step,
   output logic             dir_chg,
   output logic             jump_err,
   output logic             stall,
   output logic [POS_W-1:0] pos,
   output logic [3:0]       err_cnt,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_UP    = 2'd1,
      ST_DOWN  = 2'd2,
      ST_STALL = 2'd3
   } state_t;

   localparam logic [3:0] SAME_SAT  = 4'(STALL_LIM);
   localparam logic [3:0] SAME_TRIG = 4'(STALL_LIM - 1);

   state_t           state_q, state_d;
   logic [2:0]       prev_q, prev_d;
   logic [3:0]       same_q, same_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             dir_chg_q, dir_chg_d;
   logic             jump_err_q, jump_err_d;
   logic             stall_q, stall_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [3:0]       err_cnt_q, err_cnt_d;
   logic [2:0]       diff;

   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      same_d     = same_q;
      dir_d      = dir_q;
      step_d     = 1'b0;
      dir_chg_d  = 1'b0;
      jump_err_d = 1'b0;
      stall_d    = stall_q;
      pos_d      = pos_q;
      err_cnt_d  = err_cnt_q;
      diff       = cnt_in - prev_q;

      if (en) begin
         prev_d = cnt_in;
         if (state_q == ST_INIT) begin
            state_d = ST_UP;
         end else begin
            case (diff)
               3'd0: begin
                  if (same_q != SAME_SAT) same_d = same_q + 4'd1;
                  if (same_d >= SAME_TRIG) begin
                     state_d = ST_STALL;
                     stall_d = 1'b1;
                  end
               end
               3'd1: begin
                  pos_d     = pos_q + POS_W'(1);
                  dir_d     = 1'b1;
                  step_d    = 1'b1;
                  dir_chg_d = ~dir_q;
                  state_d   = ST_UP;
                  stall_d   = 1'b0;
                  same_d    = 4'd0;
               end
               3'd7: begin
                  pos_d     = pos_q - POS_W'(1);
                  dir_d     = 1'b0;
                  step_d    = 1'b1;
                  dir_chg_d = dir_q;
                  state_d   = ST_DOWN;
                  stall_d   = 1'b0;
                  same_d    = 4'd0;
               end
               default: begin
                  // A jump keeps direction; the state simply re-aligns with it.
                  jump_err_d = 1'b1;
                  if (err_cnt_q != 4'd15) err_cnt_d = err_cnt_q + 4'd1;
                  state_d    = dir_q ? ST_UP : ST_DOWN;
                  stall_d    = 1'b0;
                  same_d     = 4'd0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_INIT;
         prev_q     <= 3'd0;
         same_q     <= 4'd0;
         dir_q      <= 1'b1;
         step_q     <= 1'b0;
         dir_chg_q  <= 1'b0;
         jump_err_q <= 1'b0;
         stall_q    <= 1'b0;
         pos_q      <= '0;
         err_cnt_q  <= 4'd0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         same_q     <= same_d;
         dir_q      <= dir_d;
         step_q     <= step_d;
         dir_chg_q  <= dir_chg_d;
         jump_err_q <= jump_err_d;
         stall_q    <= stall_d;
         pos_q      <= pos_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign dir       = dir_q;
   assign step      = step_q;
   assign dir_chg   = dir_chg_q;
   assign jump_err  = jump_err_q;
   assign stall     = stall_q;
   assign pos       = pos_q;
   assign err_cnt   = err_cnt_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_count_direction_decoder.sv
// Bench for count_direction_decoder: directed and random samples, expected outputs
// from a behavioural model queued per sample and checked one cycle later.
module tb_count_direction_decoder;

   localparam int POS_W     = 8;
   localparam int STALL_LIM = 4;
   localparam logic [1:0] S_INIT = 2'd0, S_UP = 2'd1, S_DOWN = 2'd2, S_STALL = 2'd3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic [2:0]       cnt_in = 3'd0;
   logic             dir, step, dir_chg, jump_err, stall;
   logic [POS_W-1:0] pos;
   logic [3:0]       err_cnt;
   logic [1:0]       state_dbg;

   typedef struct packed {
      logic             dir;
      logic             step;
      logic             dir_chg;
      logic             jump_err;
      logic             stall;
      logic [POS_W-1:0] pos;
      logic [3:0]       err_cnt;
      logic [1:0]       st;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // behavioural model state
   bit       m_started;
   bit [2:0] m_prev;
   int       m_same;
   bit       m_dir;
   int       m_pos;
   int       m_err;
   bit       m_stall;
   bit [2:0] cur;

   count_direction_decoder #(.POS_W(POS_W), .STALL_LIM(STALL_LIM)) dut (
      .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in),
      .dir(dir), .step(step), .dir_chg(dir_chg), .jump_err(jump_err),
      .stall(stall), .pos(pos), .err_cnt(err_cnt), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
      end
   endtask

   task automatic model_reset();
      m_started = 1'b0;
      m_prev    = 3'd0;
      m_same    = 0;
      m_dir     = 1'b1;
      m_pos     = 0;
      m_err     = 0;
      m_stall   = 1'b0;
   endtask

   // Apply one sample to the model and return the outputs it should produce.
   task automatic model_step(input logic e, input logic [2:0] c, output exp_t x);
      int d;
      x = '0;
      if (e) begin
         if (!m_started) begin
            m_started = 1'b1;
         end else begin
            d = (int'(c) - int'(m_prev) + 8) % 8;
            if (d == 0) begin
               m_same = (m_same + 1 > STALL_LIM) ? STALL_LIM : m_same + 1;
               if (m_same >= STALL_LIM - 1) m_stall = 1'b1;
            end else if (d == 1 || d == 7) begin
               x.step    = 1'b1;
               x.dir_chg = (m_dir != (d == 1));
               m_dir     = (d == 1);
               m_pos     = m_pos + ((d == 1) ? 1 : -1);
               m_stall   = 1'b0;
               m_same    = 0;
            end else begin
               x.jump_err = 1'b1;
               m_err      = (m_err < 15) ? m_err + 1 : 15;
               m_stall    = 1'b0;
               m_same     = 0;
            end
         end
         m_prev = c;
      end
      x.dir     = m_dir;
      x.stall   = m_stall;
      x.pos     = POS_W'(m_pos);
      x.err_cnt = 4'(m_err);
      x.st      = !m_started ? S_INIT : (m_stall ? S_STALL : (m_dir ? S_UP : S_DOWN));
   endtask

   task automatic sample(input logic e, input logic [2:0] c);
      exp_t x;
      @(negedge clk);
      en     = e;
      cnt_in = c;
      if (e) cur = c;
      model_step(e, c, x);
      exp_q.push_back(x);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_dir"}, 32'(dir), 32'd1);
      chk({tag, "_step"}, 32'(step), 32'd0);
      chk({tag, "_dir_chg"}, 32'(dir_chg), 32'd0);
      chk({tag, "_jump_err"}, 32'(jump_err), 32'd0);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_pos"}, 32'(pos), 32'd0);
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
      chk({tag, "_state"}, 32'(state_dbg), 32'(S_INIT));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_values("reset");
      model_reset();
      rst = 1'b1;
   endtask

   // Reset asserted between edges, outputs checked before the next clock edge.
   task automatic async_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      en  = 1'b0;
      #1;
      check_reset_values("async_reset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // monitor: one expected entry per sample, compared after the following edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dir", 32'(dir), 32'(e.dir));
            chk("step", 32'(step), 32'(e.step));
            chk("dir_chg", 32'(dir_chg), 32'(e.dir_chg));
            chk("jump_err", 32'(jump_err), 32'(e.jump_err));
            chk("stall", 32'(stall), 32'(e.stall));
            chk("pos", 32'(pos), 32'(e.pos));
            chk("err_cnt", 32'(err_cnt), 32'(e.err_cnt));
            chk("state", 32'(state_dbg), 32'(e.st));
         end
      end
   end

   initial begin
      int r;
      model_reset();
      cur = 3'd0;
      do_reset();

      // idle cycle, then plain up count
      sample(1'b0, 3'd5);
      for (int i = 0; i < 4; i++) sample(1'b1, 3'(i));

      // up across the wrap, then a reversal back down
      do_reset();
      sample(1'b1, 3'd6);
      sample(1'b1, 3'd7);
      sample(1'b1, 3'd0);
      sample(1'b1, 3'd7);
      sample(1'b1, 3'd6);

      // repeated jumps drive the error count into saturation
      do_reset();
      for (int i = 0; i < 20; i++) begin
         sample(1'b1, 3'd2);
         sample(1'b1, 3'd5);
      end

      // stall with an idle gap, then recovery by an up step
      do_reset();
      sample(1'b1, 3'd4);
      sample(1'b1, 3'd4);
      sample(1'b0, 3'd1);
      sample(1'b0, 3'd4);
      sample(1'b1, 3'd4);
      sample(1'b1, 3'd4);
      sample(1'b1, 3'd4);
      sample(1'b1, 3'd5);

      // position wrap at the signed boundary
      do_reset();
      sample(1'b1, 3'd0);
      for (int i = 1; i <= 128; i++) sample(1'b1, 3'(i));
      sample(1'b1, 3'(127));

      // asynchronous reset in the middle of a sequence
      sample(1'b1, 3'd1);
      sample(1'b1, 3'd2);
      async_reset();
      sample(1'b1, 3'd3);
      sample(1'b1, 3'd4);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 15) begin
            sample(1'b0, 3'($urandom_range(0, 7)));
         end else if (r < 50) begin
            sample(1'b1, cur + 3'd1);
         end else if (r < 75) begin
            sample(1'b1, cur - 3'd1);
         end else if (r < 88) begin
            sample(1'b1, cur);
         end else begin
            sample(1'b1, 3'($urandom_range(0, 7)));
         end
      end

      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
